// File: rtl/mem_access_pkg.sv
// Shared types and widths for the load/store front end: request record,
// sequencer states and the memory-side address/data widths.
package mem_access_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request buffer between the core handshake and the memory sequencer.
// Head entry stays visible until popped, so the sequencer reads it in place.
module req_fifo
    import mem_access_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clka,
    input  logic restart,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(QDEPTH);

    req_t             slots [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clka) begin
        if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (push)
            slots[wr_ptr] <= din;
    end

    assign head  = slots[rd_ptr];
    assign full  = (count == DEPTH);
    assign empty = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: queues core byte requests and sequences them onto the
// data memory pins, returning load data through a valid/ready response port.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RD_WAIT = 1,
    parameter int QDEPTH  = 2
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LAST_CNT = 3'(RD_WAIT - 1);

    state_t            state;
    state_t            next_state;
    logic [2:0]        rd_cnt;
    req_t              in_req;
    req_t              head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last_read;
    logic              next_re;
    logic              next_we;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;

    assign in_req.write = req_write;
    assign in_req.addr  = req_addr;
    assign in_req.wdata = req_wdata;

    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign last_read = (state == READ) && (rd_cnt == LAST_CNT);
    assign pop       = (state == WRITE) || last_read;
    assign busy      = !empty || (state != IDLE);

    req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clka    (clka),
        .restart (restart),
        .push    (push),
        .pop     (pop),
        .din     (in_req),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clka) begin
        if (restart) begin
            state  <= IDLE;
            rd_cnt <= 3'd0;
        end else begin
            state  <= next_state;
            rd_cnt <= (state == READ && !last_read) ? rd_cnt + 3'd1 : 3'd0;
        end
    end

    // A load may only start once the response slot is free or being drained.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head.write)
                        next_state = WRITE;
                    else if (!rsp_valid || rsp_ready)
                        next_state = READ;
                end
            end
            WRITE:   next_state = IDLE;
            READ:    next_state = last_read ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    // Memory pins are registered copies of what the upcoming state drives,
    // so they line up exactly with the cycles spent in WRITE or READ.
    always_comb begin
        next_we    = 1'b0;
        next_re    = 1'b0;
        next_addr  = '0;
        next_wdata = '0;
        case (next_state)
            WRITE: begin
                next_we    = 1'b1;
                next_addr  = head.addr;
                next_wdata = head.wdata;
            end
            READ: begin
                next_re   = 1'b1;
                next_addr = head.addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
        end else begin
            mem_write_enable <= next_we;
            mem_read_enable  <= next_re;
            mem_addr         <= next_addr;
            mem_wdata        <= next_wdata;
            if (last_read) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem_rdata;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural memory beside each instance and a
// reference model that predicts load data from request acceptance order.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int RD_WAIT   = 1;
    localparam int RD_WAIT_B = 3;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic       restart;
    logic       req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [3:0] req_addr, mem_addr;
    logic [7:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
    logic       mem_read_enable, mem_write_enable, busy;

    logic       b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
    logic [3:0] b_req_addr, b_mem_addr;
    logic [7:0] b_req_wdata, b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic       b_mem_read_enable, b_mem_write_enable, b_busy;

    mem_access_unit #(.RD_WAIT(RD_WAIT), .QDEPTH(2)) dut (
        .clka(clka), .restart(restart), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_unit #(.RD_WAIT(RD_WAIT_B), .QDEPTH(2)) dut_b (
        .clka(clka), .restart(restart), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .mem_read_enable(b_mem_read_enable), .mem_write_enable(b_mem_write_enable),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Behavioural 16-byte memories; the main one can be preloaded and is
    // cleared by restart so post-reset loads read zero.
    logic [7:0] mem [16];
    logic [7:0] mem_b [16];
    logic       pl_en;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clka) begin
        if (restart) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else begin
            if (mem_write_enable) mem[mem_addr] <= mem_wdata;
            if (pl_en) mem[pl_addr] <= pl_data;
        end
        if (b_mem_write_enable) mem_b[b_mem_addr] <= b_mem_wdata;
    end
    assign mem_rdata   = mem_read_enable   ? mem[mem_addr]     : 8'h00;
    assign b_mem_rdata = b_mem_read_enable ? mem_b[b_mem_addr] : 8'h00;

    int         cyc = 0;
    int         we_count = 0, re_count = 0, re_b_count = 0, rsp_hi_count = 0;
    logic [3:0] we_addr_seen = 4'h0;
    logic [7:0] we_data_seen = 8'h00;
    logic [7:0] got_data [$];

    always @(posedge clka) cyc <= cyc + 1;

    always @(negedge clka) begin
        if (mem_write_enable) begin
            we_count++;
            we_addr_seen = mem_addr;
            we_data_seen = mem_wdata;
        end
        if (mem_read_enable) re_count++;
        if (b_mem_read_enable) re_b_count++;
        if (rsp_valid) rsp_hi_count++;
        if (rsp_valid && rsp_ready && !restart) got_data.push_back(rsp_rdata);
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [16];
    logic [7:0] exp_data [$];

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Present one request until accepted; the model records it at acceptance.
    task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input bit rand_rdy, output int acc_cyc);
        bit   done;
        logic rdy;
        done = 0;
        acc_cyc = -1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        for (int n = 0; n < 60 && !done; n++) begin
            if (rand_rdy) rsp_ready = ($urandom_range(0, 2) != 0);
            rdy = req_ready;
            step();
            if (rdy) begin
                done = 1;
                acc_cyc = cyc;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL accept_timeout addr=%h got=not_accepted required=accepted", a);
        end else if (wr) begin
            ref_mem[a] = d;
        end else begin
            exp_data.push_back(ref_mem[a]);
        end
    endtask

    task automatic test_reset();
        restart = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h7;
        step();
        step();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        checks++;
        if ({rsp_valid, rsp_rdata, mem_read_enable, mem_write_enable, mem_addr, mem_wdata, busy, req_ready}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h required=%h",
                     {rsp_valid, rsp_rdata, mem_read_enable, mem_write_enable, mem_addr, mem_wdata, busy, req_ready},
                     {1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1});
        end
        restart = 1'b0; req_valid = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || got_data.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_drop busy=%b rsps=%0d required busy=0 rsps=0", busy, got_data.size());
        end
    endtask

    task automatic test_store_load();
        int a0, a1, rcyc, base_we, g0;
        g0 = got_data.size();
        rsp_ready = 1'b1;
        base_we = we_count;
        send(1'b1, 4'h3, 8'h5A, 0, a0);
        send(1'b0, 4'h3, 8'h00, 0, a1);
        for (int n = 0; n < 20 && !rsp_valid; n++) step();
        rcyc = cyc;
        checks++;
        if (rsp_valid !== 1'b1 || rcyc != a1 + 2 + RD_WAIT) begin
            errors++;
            $display("[TB] FAIL store_load_latency got=%0d required=%0d", rcyc - a1, 2 + RD_WAIT);
        end
        checks++;
        if (rsp_rdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL store_load_data got=%02h required=5a", rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_load_pulse got=%b required=0", rsp_valid);
        end
        checks++;
        if (we_count - base_we != 1 || we_addr_seen !== 4'h3 || we_data_seen !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL store_write_pins cycles=%0d addr=%h data=%02h required 1/3/5a",
                     we_count - base_we, we_addr_seen, we_data_seen);
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL store_load_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, g0;
        g0 = got_data.size();
        rsp_ready = 1'b1;
        preload(4'h4, 8'hA4);
        preload(4'h5, 8'hB5);
        preload(4'h6, 8'hC6);
        send(1'b0, 4'h4, 8'h00, 0, a0);
        send(1'b0, 4'h5, 8'h00, 0, a1);
        checks++;
        if (a1 != a0 + 1 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full gap=%0d ready=%b required gap=1 ready=0", a1 - a0, req_ready);
        end
        send(1'b0, 4'h6, 8'h00, 0, a2);
        checks++;
        if (a2 != a0 + 2 + RD_WAIT) begin
            errors++;
            $display("[TB] FAIL b2b_third_accept got=%0d required=%0d", a2 - a0, 2 + RD_WAIT);
        end
        for (int n = 0; n < 100 && got_data.size() != exp_data.size(); n++) step();
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("[TB] FAIL b2b_drain got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL b2b_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        int acc, base_re, g0;
        g0 = got_data.size();
        preload(4'h1, 8'h11);
        preload(4'h2, 8'h22);
        rsp_ready = 1'b0;
        send(1'b0, 4'h1, 8'h00, 0, acc);
        send(1'b0, 4'h2, 8'h00, 0, acc);
        for (int n = 0; n < 20 && !rsp_valid; n++) step();
        base_re = re_count;
        repeat (5) step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h11) begin
            errors++;
            $display("[TB] FAIL hold_rsp got=%b/%02h required=1/11", rsp_valid, rsp_rdata);
        end
        checks++;
        if (re_count != base_re) begin
            errors++;
            $display("[TB] FAIL hold_no_read got=%0d required=0", re_count - base_re);
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 50 && got_data.size() != exp_data.size(); n++) step();
        step();
        checks++;
        if (re_count - base_re != RD_WAIT) begin
            errors++;
            $display("[TB] FAIL second_read_cycles got=%0d required=%0d", re_count - base_re, RD_WAIT);
        end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("[TB] FAIL hold_drain got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL hold_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_addr_boundary();
        int acc, g0;
        g0 = got_data.size();
        rsp_ready = 1'b1;
        preload(4'h0, 8'h00);
        preload(4'h7, 8'h77);
        send(1'b1, 4'hF, 8'hC3, 0, acc);
        send(1'b0, 4'hF, 8'h00, 0, acc);
        send(1'b0, 4'h0, 8'h00, 0, acc);
        for (int n = 0; n < 50 && got_data.size() != exp_data.size(); n++) step();
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("[TB] FAIL boundary_drain got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL boundary_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_restart_midread();
        int acc, base_hi, g0;
        rsp_ready = 1'b1;
        preload(4'h5, 8'h55);
        send(1'b0, 4'h5, 8'h00, 0, acc);
        for (int n = 0; n < 20 && !mem_read_enable; n++) step();
        checks++;
        if (mem_read_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_reach_read got=%b required=1", mem_read_enable);
        end
        restart = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_wdata = 8'hFF;
        step();
        checks++;
        if ({rsp_valid, rsp_rdata, mem_read_enable, mem_write_enable, mem_addr, mem_wdata, busy}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL restart_outputs got=%h required=%h",
                     {rsp_valid, rsp_rdata, mem_read_enable, mem_write_enable, mem_addr, mem_wdata, busy},
                     {1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0});
        end
        restart = 1'b0; req_valid = 1'b0;
        void'(exp_data.pop_back());
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        g0 = got_data.size();
        base_hi = rsp_hi_count;
        repeat (3) step();
        checks++;
        if (rsp_hi_count != base_hi || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_abandon rsp_cycles=%0d busy=%b required 0/0", rsp_hi_count - base_hi, busy);
        end
        send(1'b0, 4'($urandom_range(0, 15)), 8'h00, 0, acc);
        for (int n = 0; n < 50 && got_data.size() != exp_data.size(); n++) step();
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("[TB] FAIL restart_drain got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL restart_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_random();
        int acc, g0;
        g0 = got_data.size();
        for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) begin
                rsp_ready = ($urandom_range(0, 2) != 0);
                step();
            end
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1, acc);
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 300 && got_data.size() != exp_data.size(); n++) step();
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("[TB] FAIL random_drain got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        for (int k = g0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== exp_data[k]) begin
                errors++;
                $display("[TB] FAIL random_rsp[%0d] got=%02h required=%02h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_rd_wait3();
        int         base, acc, rcyc;
        logic [3:0] a;
        logic [7:0] d;
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(1, 255));
            base = re_b_count;
            b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = a; b_req_wdata = d;
            step();
            b_req_write = 1'b0; b_req_wdata = 8'h00;
            step();
            acc = cyc;
            b_req_valid = 1'b0;
            for (int n = 0; n < 40 && !b_rsp_valid; n++) step();
            rcyc = cyc;
            checks++;
            if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== d) begin
                errors++;
                $display("[TB] FAIL rdwait3_data got=%b/%02h required=1/%02h", b_rsp_valid, b_rsp_rdata, d);
            end
            checks++;
            if (rcyc != acc + 2 + RD_WAIT_B) begin
                errors++;
                $display("[TB] FAIL rdwait3_latency got=%0d required=%0d", rcyc - acc, 2 + RD_WAIT_B);
            end
            checks++;
            if (re_b_count - base != RD_WAIT_B) begin
                errors++;
                $display("[TB] FAIL rdwait3_enable_cycles got=%0d required=%0d", re_b_count - base, RD_WAIT_B);
            end
            step();
            for (int n = 0; n < 10 && b_busy; n++) step();
        end
    endtask

    initial begin
        restart = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 4'h0; b_req_wdata = 8'h00; b_rsp_ready = 1'b1;
        pl_en = 1'b0; pl_addr = 4'h0; pl_data = 8'h00;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_rsp_backpressure();
        test_addr_boundary();
        test_restart_midread();
        test_random();
        test_rd_wait3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
